// File: rtl/pwm_pkg.sv
// Types and widths shared by the PWM capture and generator blocks.
package pwm_pkg;

  localparam int PWM_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_edge_detect.sv
// Samples the PWM input (through an optional 2-flop synchronizer when PWM_CAPTURE_SYNC_EN is defined) and flags edges.
// Latency: edges are visible 1 clk after the sampling edge, or 3 clk with the synchronizer.
// Backpressure: none; the input is sampled every cycle.
module pwm_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic s_lvl,
  output logic rise,
  output logic fall
);

  logic din;
  logic s;
  logic s_q;

`ifdef PWM_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pulse_in};
    end
  end

  assign din = sync_q[1];
`else
  assign din = pulse_in;
`endif

  // Registered sample plus one cycle of history; both cleared so no edge fires out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s   <= 1'b0;
      s_q <= 1'b0;
    end else begin
      s   <= din;
      s_q <= s;
    end
  end

  assign s_lvl = s;
  assign rise  = s & ~s_q;
  assign fall  = ~s & s_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in clk ticks and flags a stuck input; PWM_CAPTURE_SYNC_EN adds an input synchronizer.
// Latency: meas_valid 1 clk after the edge sampling the rising input (3 clk with PWM_CAPTURE_SYNC_EN).
// Backpressure: none; each result is a 1-cycle strobe and outputs hold until the next one.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int          CNT_W         = PWM_CNT_W,
  parameter int unsigned TIMEOUT_TICKS = 2**24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period_ticks,
  output logic [CNT_W-1:0] high_ticks,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_TICKS);

  logic             s_lvl;
  logic             rise;
  logic             fall;
  logic             timeout;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_high;

  cap_state_t state_q;
  cap_state_t state_d;
  logic       publish;
  logic       capture_high;
  logic       set_stuck;

  pwm_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .s_lvl    (s_lvl),
    .rise     (rise),
    .fall     (fall)
  );

  assign timeout = (cnt == TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An edge arriving in the same cycle as the timeout wins over the stuck declaration.
  always_comb begin
    state_d      = state_q;
    publish      = 1'b0;
    capture_high = 1'b0;
    set_stuck    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d      = LOW;
          capture_high = 1'b1;
        end else if (!rise && timeout) begin
          state_d   = IDLE;
          set_stuck = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          publish = 1'b1;
        end else if (!fall && timeout) begin
          state_d   = IDLE;
          set_stuck = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Tick counter restarts at 1 on every rise and saturates so a long gap never wraps into a short one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (!timeout) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_high <= '0;
    end else if (capture_high) begin
      hold_high <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_ticks <= '0;
      high_ticks   <= '0;
      meas_valid   <= 1'b0;
    end else begin
      meas_valid <= publish;
      if (publish) begin
        period_ticks <= cnt;
        high_ticks   <= hold_high;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else if (rise) begin
      stuck <= 1'b0;
    end else if (set_stuck) begin
      stuck       <= 1'b1;
      stuck_level <= s_lvl;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Drives pulse_in from a behavioural PWM source and compares every cycle against an event-level reference model.
module tb_pwm_capture;

  localparam int CNT_W = 32;
  localparam int TMO   = 1000;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst;
  logic             pulse_in;
  logic [CNT_W-1:0] period_ticks;
  logic [CNT_W-1:0] high_ticks;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  pwm_capture #(
    .CNT_W         (CNT_W),
    .TIMEOUT_TICKS (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pulse_in     (pulse_in),
    .period_ticks (period_ticks),
    .high_ticks   (high_ticks),
    .meas_valid   (meas_valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Expected outputs per clock edge, written LAT edges ahead by the model.
  logic [31:0] e_period [8];
  logic [31:0] e_high   [8];
  logic        e_valid  [8];
  logic        e_stuck  [8];
  logic        e_slvl   [8];

  // Reference model state: time of last rise, high time of the current period, tracking flag.
  bit          m_track;
  bit          m_seen_fall;
  int          m_rise_t;
  int          m_hh;
  bit          m_prev;
  int          m_period;
  int          m_high;
  bit          m_stuck;
  bit          m_slvl;

  function automatic int sat(input int v);
    return (v > TMO) ? TMO : v;
  endfunction

  task automatic put_exp(input int e, input bit pub);
    e_period[e % 8] = m_period;
    e_high[e % 8]   = m_high;
    e_valid[e % 8]  = pub;
    e_stuck[e % 8]  = m_stuck;
    e_slvl[e % 8]   = m_slvl;
  endtask

  task automatic model(input int n, input bit x, input bit r);
    bit pub;
    bit is_rise;
    bit is_fall;
    if (r) begin
      m_track = 0; m_seen_fall = 0; m_rise_t = 0; m_hh = 0; m_prev = 0;
      m_period = 0; m_high = 0; m_stuck = 0; m_slvl = 0;
      for (int k = 0; k <= LAT; k++) put_exp(n + k, 1'b0);
      return;
    end
    pub     = 0;
    is_rise = x && !m_prev;
    is_fall = !x && m_prev;
    if (is_rise) begin
      if (m_track && m_seen_fall) begin
        m_period = sat(n - m_rise_t);
        m_high   = m_hh;
        pub      = 1;
      end
      m_rise_t    = n;
      m_track     = 1;
      m_seen_fall = 0;
      m_stuck     = 0;
    end else if (is_fall) begin
      if (m_track && !m_seen_fall) begin
        m_hh        = sat(n - m_rise_t);
        m_seen_fall = 1;
      end
    end else if (m_track && (n - m_rise_t) >= TMO) begin
      m_stuck = 1;
      m_slvl  = x;
      m_track = 0;
    end
    m_prev = x;
    put_exp(n + LAT, pub);
  endtask

  int edge_n = 0;
  int phase  = 0;

  task automatic step(input logic lvl, input logic r);
    int e;
    pulse_in = lvl;
    rst      = r;
    edge_n++;
    model(edge_n, lvl, r);
    @(posedge clk);
    #1;
    e = edge_n % 8;
    chk_val("meas_valid",   {31'd0, meas_valid},  {31'd0, e_valid[e]});
    chk_val("period_ticks", period_ticks,         e_period[e]);
    chk_val("high_ticks",   high_ticks,           e_high[e]);
    chk_val("stuck",        {31'd0, stuck},       {31'd0, e_stuck[e]});
    chk_val("stuck_level",  {31'd0, stuck_level}, {31'd0, e_slvl[e]});
  endtask

  task automatic run(input int per, input int duty, input int n);
    for (int i = 0; i < n; i++) begin
      if (phase >= per) phase = 0;
      step(phase < duty, 1'b0);
      phase++;
      if (phase >= per) phase = 0;
    end
  endtask

  initial begin
    int per;
    int duty;
    for (int k = 0; k < 8; k++) begin
      e_period[k] = '0; e_high[k] = '0; e_valid[k] = 1'b0; e_stuck[k] = 1'b0; e_slvl[k] = 1'b0;
    end
    pulse_in = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk_val("reset_period", period_ticks, 32'd0);
    chk_val("reset_valid",  {31'd0, meas_valid}, 32'd0);

    phase = 0;
    run(100, 50, 600);
    chk_val("s1_period", period_ticks, 32'd100);
    chk_val("s1_high",   high_ticks,   32'd50);
    chk_val("s1_stuck",  {31'd0, stuck}, 32'd0);

    run(100, 25, 400);
    chk_val("s2_high25", high_ticks, 32'd25);
    run(100, 75, 400);
    chk_val("s2_high75",   high_ticks,   32'd75);
    chk_val("s2_period75", period_ticks, 32'd100);

    run(100, 0, 1200);
    chk_val("s3_stuck",     {31'd0, stuck},       32'd1);
    chk_val("s3_stuck_lvl", {31'd0, stuck_level}, 32'd0);
    run(100, 50, 400);
    chk_val("s3_unstuck", {31'd0, stuck}, 32'd0);
    chk_val("s3_high",    high_ticks,     32'd50);

    run(100, 100, 1200);
    chk_val("s4_stuck",     {31'd0, stuck},       32'd1);
    chk_val("s4_stuck_lvl", {31'd0, stuck_level}, 32'd1);
    run(1000, 500, 3500);
    chk_val("s4_period_tmo", period_ticks,   32'd1000);
    chk_val("s4_high_tmo",   high_ticks,     32'd500);
    chk_val("s4_no_stuck",   {31'd0, stuck}, 32'd0);

    run(100, 50, 250);
    while (phase != 10) run(100, 50, 1);
    step(1'b1, 1'b1);
    phase++;
    chk_val("s5_rst_period", period_ticks,         32'd0);
    chk_val("s5_rst_high",   high_ticks,           32'd0);
    chk_val("s5_rst_valid",  {31'd0, meas_valid}, 32'd0);
    chk_val("s5_rst_stuck",  {31'd0, stuck},      32'd0);
    run(100, 50, 500);

    phase = 0;
    run(2, 1, 100);
    chk_val("min_period", period_ticks, 32'd2);
    chk_val("min_high",   high_ticks,   32'd1);
    run(37, 1, 300);
    chk_val("glitch_high", high_ticks, 32'd1);

    for (int seg = 0; seg < 16; seg++) begin
      per  = $urandom_range(200, 2);
      duty = (seg % 4 == 3) ? 1 : $urandom_range(per, 0);
      run(per, duty, $urandom_range(700, 200));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
